sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in/parallel-out deserializer; receive-side counterpart of the team's PISO shifter.
- Collects N serial bits, MSB first (matching the PISO shift-out order), into a word.
- Presents each word on a valid/ready parallel output with a one-word holding stage and sticky overrun detection.
- Sits at the receive end of the serial link, feeding downstream parallel logic.

Parameters:
- N, 5, word width in bits (N >= 2).
- CW, $clog2(N), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, asynchronous, active-low.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is sampled on this edge when high.
- frame_start  input  1  marks the current bit as bit 0 (MSB) of a new word; aborts any partial word.
- parallel_out  output  N  assembled word, valid while out_valid=1.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rstn=0, async): shift_reg=0, count=0, state=IDLE, parallel_out=0, out_valid=0, overrun=0 (parity_err=0 if enabled).
- States: IDLE (count=0, no partial word) and SHIFT (1..N-1 bits held).
- Accepted bit (serial_valid=1):
  - shift_reg <= {shift_reg[N-2:0], serial_in}; count increments.
  - IDLE->SHIFT on first bit.
- Word completion: the accepted bit with count==N-1.
  - Completed word = {shift_reg[N-2:0], serial_in}.
  - count->0, state->IDLE.
  - Bits are consumed on the same edge; no bubble. Back-to-back words at full serial rate are supported.
- Latency: out_valid and parallel_out update on the completion edge, i.e. visible the cycle after the Nth bit is presented.
- Holding stage, evaluated at each completion:
  - If !out_valid, or out_valid && out_ready: load the completed word, out_valid=1.
  - If out_valid && !out_ready: drop the new word, keep the held word, set overrun=1.
- Handshake:
  - out_valid && out_ready with no completion: out_valid->0 next edge; parallel_out holds its last value.
  - parallel_out is stable while out_valid && !out_ready.
- frame_start:
  - With serial_valid: discard the partial word; this bit becomes bit 0 and count=1. Exception: N=... not applicable, since N >= 2.
  - Without serial_valid: count->0, state->IDLE, shift_reg unchanged (don't-care).
  - Never affects the holding stage.
- serial_valid=0: no shift; gaps of any length are allowed mid-word.
- Overrun:
  - Cleared by overrun_clr.
  - If a set and a clear occur on the same edge, set wins.
- Reset mid-word: the partial word is lost; the next accepted bit is bit 0.

Optional Feature:
Macro SIPO_DESER_PARITY_EN.
- Defined:
  - Each frame is N+1 bits: N data bits then one even-parity bit; the counter runs 0..N.
  - The data word is loaded on the parity-bit edge.
  - Adds port parity_err (output, 1), sampled with out_valid: high when the XOR of data and parity bit is 1.
  - The word is still delivered.
  - The overrun rules apply at the parity-bit edge.
- Undefined: N-bit frames; no parity_err port.

Decomposition:
- Package sipo_deser_pkg: state enum (IDLE, SHIFT) as typedef sipo_state_t; count-width helper function.
- One natural sub-module, sipo_out_stage: the holding register with valid/ready and overrun logic, parameterised by N. The top level holds the shifter, counter and FSM.

Test Plan (N=5):
- Basic word: bits 1,0,1,1,0 on consecutive cycles, out_ready=1 -> parallel_out=5'b10110, out_valid high one cycle after the 5th bit, then low.
- Gapped bits: same bits with serial_valid low 3 cycles between each -> same 5'b10110, single out_valid pulse.
- Back-to-back with backpressure:
  - Words 5'b11001 then 5'b00111 streamed continuously, out_ready=0 -> parallel_out stays 5'b11001, overrun=1 after the 2nd word.
  - overrun_clr -> overrun=0.
- Simultaneous: word 1 held; word 2 completes on the same edge as out_ready=1 -> parallel_out=word 2, out_valid stays 1, overrun=0.
- frame_start mid-word: bits 1,1,1 then frame_start with bits 0,1,0,1,0 -> single word 5'b01010.
- Reset mid-word: 3 bits, rstn pulse, then 1,0,0,0,1 -> 5'b10001 with all outputs 0 during reset.
- Parity (macro defined): 1,0,1,1,0 plus parity bit 1 -> parity_err=0; plus parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel receiver.
package sipo_deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    // Bit-counter width for a frame of n bits (counter runs 0..n-1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-word holding register with valid/ready handshake and sticky overrun.
// Carries a parity_err flag alongside the word when SIPO_DESER_PARITY_EN is defined.
module sipo_out_stage #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         word_done,
    input  logic [N-1:0] word,
`ifdef SIPO_DESER_PARITY_EN
    input  logic         parity_bad,
    output logic         parity_err,
`endif
    input  logic         out_ready,
    input  logic         overrun_clr,
    output logic [N-1:0] parallel_out,
    output logic         out_valid,
    output logic         overrun
);

    logic load_c;
    logic drop_c;

    // A completed word is taken if the slot is empty or being emptied this edge.
    assign load_c = word_done && (!out_valid || out_ready);
    assign drop_c = word_done && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            if (load_c) begin
                parallel_out <= word;
                out_valid    <= 1'b1;
`ifdef SIPO_DESER_PARITY_EN
                parity_err   <= parity_bad;
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Set takes priority over a same-edge clear.
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer, MSB first, with a valid/ready output stage.
// Define SIPO_DESER_PARITY_EN for N+1-bit frames ending in an even-parity bit.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         serial_in,
    input  logic         serial_valid,
    input  logic         frame_start,
    output logic [N-1:0] parallel_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun,
    input  logic         overrun_clr
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic         parity_err
`endif
);

`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned FRAME = N + 1;
    localparam int unsigned SW    = N;
`else
    localparam int unsigned FRAME = N;
    localparam int unsigned SW    = N - 1;
`endif
    localparam int unsigned CW   = cnt_width(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    sipo_state_t   state;
    logic [CW-1:0] count;
    logic [SW-1:0] shift_reg;
    logic          word_done_c;
    logic [N-1:0]  word_c;

    assign word_done_c = serial_valid && !frame_start && (state == SHIFT) && (count == LAST);

`ifdef SIPO_DESER_PARITY_EN
    logic parity_bad_c;
    assign word_c       = shift_reg;
    assign parity_bad_c = (^shift_reg) ^ serial_in;
`else
    assign word_c = {shift_reg, serial_in};
`endif

    // Shifter, bit counter and framing FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
        end else if (serial_valid) begin
            if (frame_start) begin
                shift_reg <= SW'(serial_in);
                count     <= CW'(1);
                state     <= SHIFT;
            end else begin
                case (state)
                    IDLE: begin
                        shift_reg <= SW'({shift_reg, serial_in});
                        count     <= CW'(1);
                        state     <= SHIFT;
                    end
                    SHIFT: begin
                        if (count == LAST) begin
`ifndef SIPO_DESER_PARITY_EN
                            shift_reg <= SW'({shift_reg, serial_in});
`endif
                            count <= '0;
                            state <= IDLE;
                        end else begin
                            shift_reg <= SW'({shift_reg, serial_in});
                            count     <= count + CW'(1);
                        end
                    end
                endcase
            end
        end else if (frame_start) begin
            count <= '0;
            state <= IDLE;
        end
    end

    sipo_out_stage #(
        .N (N)
    ) u_out_stage (
        .clk          (clk),
        .rstn         (rstn),
        .word_done    (word_done_c),
        .word         (word_c),
`ifdef SIPO_DESER_PARITY_EN
        .parity_bad   (parity_bad_c),
        .parity_err   (parity_err),
`endif
        .out_ready    (out_ready),
        .overrun_clr  (overrun_clr),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser at N=5.
module tb_sipo_deser;

    localparam int unsigned N = 5;

    logic         clk = 1'b0;
    logic         rstn;
    logic         serial_in;
    logic         serial_valid;
    logic         frame_start;
    logic [N-1:0] parallel_out;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         overrun_clr;
`ifdef SIPO_DESER_PARITY_EN
    logic         parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_deser #(.N(N)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
`ifdef SIPO_DESER_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    // Present one cycle of inputs, then return 1 time unit after the edge.
    task automatic drive(input logic sv, input logic sin, input logic fs);
        serial_valid = sv;
        serial_in    = sin;
        frame_start  = fs;
        @(posedge clk);
        #1;
        serial_valid = 1'b0;
        serial_in    = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0);
    endtask

    task automatic test_reset;
        rstn = 1'b0; serial_in = 1'b0; serial_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (parallel_out !== 5'b00000) begin errors++; $display("FAIL reset_data got %b want 00000", parallel_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        drive(1, 1, 0); drive(1, 0, 0); drive(1, 1, 0); drive(1, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", out_valid); end
        drive(1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
        checks++; if (parallel_out !== 5'b10110) begin errors++; $display("FAIL basic_data got %b want 10110", parallel_out); end
        drive(0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got %b want 0", out_valid); end
        checks++; if (parallel_out !== 5'b10110) begin errors++; $display("FAIL basic_hold_data got %b want 10110", parallel_out); end
    endtask

    task automatic test_gapped;
        logic [N-1:0] w;
        logic [N-1:0] seen;
        int pulses;
        w = 5'b10110; pulses = 0; seen = '0;
        out_ready = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            drive(1'b1, w[i], 1'b0);
            if (out_valid === 1'b1) begin pulses++; seen = parallel_out; end
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, 1'b0, 1'b0);
                if (out_valid === 1'b1) begin pulses++; seen = parallel_out; end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL gapped_pulses got %0d want 1", pulses); end
        checks++; if (seen !== 5'b10110) begin errors++; $display("FAIL gapped_data got %b want 10110", seen); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        send_word(5'b11001);
        checks++; if (out_valid !== 1'b1 || parallel_out !== 5'b11001) begin errors++; $display("FAIL bp_first got v=%b d=%b want v=1 d=11001", out_valid, parallel_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_no_overrun got %b want 0", overrun); end
        send_word(5'b00111);
        checks++; if (parallel_out !== 5'b11001) begin errors++; $display("FAIL bp_held got %b want 11001", parallel_out); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
        overrun_clr = 1'b1;
        drive(0, 0, 0);
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clr got %b want 0", overrun); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %b want 1", out_valid); end
    endtask

    task automatic test_simultaneous;
        out_ready = 1'b0;
        drive(1, 1, 0); drive(1, 0, 0); drive(1, 0, 0); drive(1, 1, 0);
        out_ready = 1'b1;
        drive(1, 1, 0);
        checks++; if (parallel_out !== 5'b10011) begin errors++; $display("FAIL simul_data got %b want 10011", parallel_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b want 1", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun got %b want 0", overrun); end
        drive(0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_drain got %b want 0", out_valid); end
    endtask

    task automatic test_frame_start;
        out_ready = 1'b1;
        drive(1, 1, 0); drive(1, 1, 0); drive(1, 1, 0);
        drive(1, 0, 1); drive(1, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fs_abort got %b want 0", out_valid); end
        drive(1, 0, 0); drive(1, 1, 0); drive(1, 0, 0);
        checks++; if (out_valid !== 1'b1 || parallel_out !== 5'b01010) begin errors++; $display("FAIL fs_word got v=%b d=%b want v=1 d=01010", out_valid, parallel_out); end
        drive(0, 0, 0);
        // frame_start without a bit drops the partial word.
        drive(1, 1, 0); drive(1, 1, 0); drive(0, 0, 1);
        drive(1, 1, 0); drive(1, 0, 0); drive(1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fs_idle_abort got %b want 0", out_valid); end
        drive(1, 1, 0); drive(1, 1, 0);
        checks++; if (out_valid !== 1'b1 || parallel_out !== 5'b10011) begin errors++; $display("FAIL fs_idle_word got v=%b d=%b want v=1 d=10011", out_valid, parallel_out); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(1, 1, 0); drive(1, 0, 0); drive(1, 1, 0);
        rstn = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0 || parallel_out !== 5'b00000 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got v=%b d=%b o=%b want 0 00000 0", out_valid, parallel_out, overrun); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_word(5'b10001);
        checks++; if (out_valid !== 1'b1 || parallel_out !== 5'b10001) begin errors++; $display("FAIL rst_mid_word got v=%b d=%b want v=1 d=10001", out_valid, parallel_out); end
        drive(0, 0, 0);
    endtask

`ifdef SIPO_DESER_PARITY_EN
    task automatic test_parity;
        out_ready = 1'b1;
        send_word(5'b10110);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL par_latency got %b want 0", out_valid); end
        drive(1, 1, 0);
        checks++; if (out_valid !== 1'b1 || parallel_out !== 5'b10110) begin errors++; $display("FAIL par_word got v=%b d=%b want v=1 d=10110", out_valid, parallel_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good got %b want 0", parity_err); end
        send_word(5'b10110);
        drive(1, 0, 0);
        checks++; if (out_valid !== 1'b1 || parity_err !== 1'b1) begin errors++; $display("FAIL par_bad got v=%b e=%b want v=1 e=1", out_valid, parity_err); end
        drive(0, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
`ifdef SIPO_DESER_PARITY_EN
        test_parity();
`else
        test_basic();
        test_gapped();
        test_back_to_back();
        test_simultaneous();
        test_frame_start();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
